// File: rtl/magnitude_comparator_4bit.sv
// Registered unsigned magnitude comparator: flags A>B / A<B / A==B one cycle after in_valid.
// Optional COMPARATOR_SIGNED_EN adds a signed_mode input for two's-complement compares.
module magnitude_comparator_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  output logic             G,
  output logic             L,
  output logic             E
);

  logic             signed_sel;
  logic [WIDTH-1:0] msb_flip;
  logic [WIDTH-1:0] a_key, b_key;
  logic             gt, lt, eq;

`ifdef COMPARATOR_SIGNED_EN
  assign signed_sel = signed_mode;
`else
  assign signed_sel = 1'b0;
`endif

  // Inverting the sign bit maps two's complement order onto unsigned order,
  // so one unsigned comparator serves both modes.
  always_comb begin
    msb_flip            = '0;
    msb_flip[WIDTH-1]   = signed_sel;
  end

  assign a_key = A ^ msb_flip;
  assign b_key = B ^ msb_flip;
  assign gt    = (a_key >  b_key);
  assign lt    = (a_key <  b_key);
  assign eq    = (a_key == b_key);

  // Flags hold across idle cycles; only out_valid marks them stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      G         <= 1'b0;
      L         <= 1'b0;
      E         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        G <= gt;
        L <= lt;
        E <= eq;
      end
    end
  end

endmodule

// File: tb/tb_magnitude_comparator_4bit.sv
// Scoreboard bench for magnitude_comparator_4bit: expected {out_valid,G,L,E} queued at drive time,
// popped and compared one edge later against an integer reference model.
module tb_magnitude_comparator_4bit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid;
  logic [W-1:0] A, B;
  logic         sm;
  logic         out_valid, G, L, E;

  always #5 clk = ~clk;

  magnitude_comparator_4bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
`ifdef COMPARATOR_SIGNED_EN
    .signed_mode(sm),
`endif
    .out_valid(out_valid), .G(G), .L(L), .E(E)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] exp_q[$];
  logic       m_v = 1'b0, m_g = 1'b0, m_l = 1'b0, m_e = 1'b0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  function automatic int to_int(input logic [W-1:0] v, input logic s);
    if (s && v[W-1]) return int'(v) - (1 << W);
    return int'(v);
  endfunction

  // Drive one cycle, predict the post-edge outputs, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic s, input string tag);
    int ai, bi;
    logic [3:0] exp, obs;
    @(negedge clk);
    rst = r; in_valid = v; A = a; B = b; sm = s;
`ifndef COMPARATOR_SIGNED_EN
    s = 1'b0;
`endif
    ai = to_int(a, s);
    bi = to_int(b, s);
    if (r) begin
      m_v = 0; m_g = 0; m_l = 0; m_e = 0;
    end else begin
      m_v = v;
      if (v) begin
        m_g = (ai > bi); m_l = (ai < bi); m_e = (ai == bi);
      end
    end
    exp_q.push_back({m_v, m_g, m_l, m_e});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    obs = {out_valid, G, L, E};
    chk(tag, obs, exp);
    if (out_valid === 1'b1)
      chk({tag, "_onehot"}, {3'b0, ($countones({G, L, E}) == 1)}, 4'b0001);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; sm = 1'b0;

    // Reset with valid data present: rst must win.
    step(1, 1, 4'h5, 4'h3, 0, "rst0");
    step(1, 1, 4'h5, 4'h3, 0, "rst1");

    // Directed back-to-back sequence with hand-derived expectations.
    step(0, 1, 4'b0000, 4'b0000, 0, "d_eq0");
    chk("d_eq0_lit", {out_valid, G, L, E}, 4'b1001);
    step(0, 1, 4'b0010, 4'b0001, 0, "d_gt");
    chk("d_gt_lit", {out_valid, G, L, E}, 4'b1100);
    step(0, 1, 4'b0100, 4'b0110, 0, "d_lt");
    chk("d_lt_lit", {out_valid, G, L, E}, 4'b1010);
    step(0, 1, 4'b1010, 4'b1010, 0, "d_eqA");
    chk("d_eqA_lit", {out_valid, G, L, E}, 4'b1001);
    step(0, 1, 4'b1111, 4'b0111, 0, "d_gtF");
    chk("d_gtF_lit", {out_valid, G, L, E}, 4'b1100);

    // Hold: flags keep last result, out_valid drops.
    step(0, 0, 4'b0000, 4'b0111, 0, "hold");
    chk("hold_lit", {out_valid, G, L, E}, 4'b0100);
    step(0, 1, 4'b1001, 4'b1100, 0, "d_lt9");
    chk("d_lt9_lit", {out_valid, G, L, E}, 4'b1010);

    // Mid-stream reset discards the in-flight result.
    step(0, 1, 4'b0010, 4'b0001, 0, "ms_pre");
    step(1, 1, 4'b0010, 4'b0001, 0, "ms_rst");
    chk("ms_rst_lit", {out_valid, G, L, E}, 4'b0000);

    // Exhaustive unsigned sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(0, 1, W'(a), W'(b), 0, "exh");

`ifdef COMPARATOR_SIGNED_EN
    step(0, 1, 4'b1111, 4'b0001, 1, "s_m1");
    chk("s_m1_lit", {out_valid, G, L, E}, 4'b1010);
    step(0, 1, 4'b1000, 4'b0111, 1, "s_min");
    chk("s_min_lit", {out_valid, G, L, E}, 4'b1010);
    step(0, 1, 4'b1111, 4'b0001, 0, "u_m1");
    chk("u_m1_lit", {out_valid, G, L, E}, 4'b1100);
    step(0, 1, 4'b1000, 4'b0111, 0, "u_min");
    chk("u_min_lit", {out_valid, G, L, E}, 4'b1100);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        step(0, 1, W'(a), W'(b), 1, "exh_s");
`endif

    step(0, 0, 4'h0, 4'h0, 0, "idle");
    chk("q_empty", {3'b0, (exp_q.size() == 0)}, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
